// File: rtl/cfg_ff_bank.sv
// cfg_ff_bank: bank of WIDTH flip-flops. The control style (D, T, SR or JK)
// is selected at run time. Illegal SR inputs (S=R=1) are caught in sticky
// per-bit flags and counted in a saturating counter.
module cfg_ff_bank #(
    parameter int unsigned           WIDTH   = 8,
    parameter int unsigned           CNT_W   = 4,
    parameter logic [WIDTH-1:0]      RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr_err,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic [WIDTH-1:0] err,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        MODE_D  = 2'b00,
        MODE_T  = 2'b01,
        MODE_SR = 2'b10,
        MODE_JK = 2'b11
    } mode_e;

    mode_e            mode_sel;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] ill;
    logic             any_ill;
    logic [WIDTH-1:0] err_nxt;
    logic [CNT_W-1:0] cnt_nxt;

    assign mode_sel = mode_e'(mode);

    // Complement output is derived from q, never separately registered
    assign qbar = ~q;

    // Per-bit next state and illegal-SR detection for the selected mode
    always_comb begin
        q_nxt = q;
        ill   = '0;
        if (en) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                unique case (mode_sel)
                    MODE_D: q_nxt[i] = a[i];
                    MODE_T: q_nxt[i] = q[i] ^ a[i];
                    MODE_SR: begin
                        unique case ({a[i], b[i]})
                            2'b00: q_nxt[i] = q[i];
                            2'b10: q_nxt[i] = 1'b1;
                            2'b01: q_nxt[i] = 1'b0;
                            2'b11: begin
                                q_nxt[i] = q[i];
                                ill[i]   = 1'b1;
                            end
                            default: q_nxt[i] = q[i];
                        endcase
                    end
                    MODE_JK: begin
                        unique case ({a[i], b[i]})
                            2'b00: q_nxt[i] = q[i];
                            2'b10: q_nxt[i] = 1'b1;
                            2'b01: q_nxt[i] = 1'b0;
                            2'b11: q_nxt[i] = ~q[i];
                            default: q_nxt[i] = q[i];
                        endcase
                    end
                    default: q_nxt[i] = q[i];
                endcase
            end
        end
    end

    assign any_ill = |ill;

    // Error flags and counter; a clear keeps any error seen in the same cycle
    always_comb begin
        err_nxt = err;
        cnt_nxt = err_cnt;
        if (clr_err) begin
            err_nxt = ill;
            cnt_nxt = any_ill ? CNT_ONE : '0;
        end else begin
            err_nxt = err | ill;
            if (any_ill && (err_cnt != CNT_MAX)) begin
                cnt_nxt = err_cnt + CNT_ONE;
            end
        end
    end

    // State registers with synchronous reset overriding all other inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            q       <= RST_VAL;
            err     <= '0;
            err_cnt <= '0;
        end else begin
            q       <= q_nxt;
            err     <= err_nxt;
            err_cnt <= cnt_nxt;
        end
    end

endmodule

// File: doc/cfg_ff_bank.md
Name: cfg_ff_bank

Overview:
- Parametrised bank of WIDTH edge-triggered flip-flops; the successor to the single-bit master-slave SR flip-flop.
- Each bank operates in one runtime-selectable mode: D, T, SR or JK.
- Detects illegal SR input (S=R=1): sets a sticky per-bit error and counts the events.
- Used as a general state-holding register where the control style is selected at run time.

Parameters:
- WIDTH, 8, number of flip-flop bits in the bank.
- CNT_W, 4, width of the illegal-event counter.
- RST_VAL, 0 (WIDTH bits), value loaded into q on reset.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  update enable; 0 = hold all state.
- mode  input  2  00 = D, 01 = T, 10 = SR, 11 = JK.
- a  input  WIDTH  per-bit primary input: D, T, S or J.
- b  input  WIDTH  per-bit secondary input: R or K; ignored in D and T modes.
- clr_err  input  1  synchronous clear of err and err_cnt.
- q  output  WIDTH  registered state.
- qbar  output  WIDTH  always ~q (combinational from q, never independently registered).
- err  output  WIDTH  sticky per-bit illegal-SR flags.
- err_cnt  output  CNT_W  saturating count of cycles containing at least one illegal SR bit.

Behaviour:
- Reset (rst=1 at the edge): q=RST_VAL, qbar=~RST_VAL, err=0, err_cnt=0. Reset overrides en, mode and clr_err.
- Latency: q reflects its inputs one edge after they are sampled. No combinational path from a, b or mode to q.
- en=0: q, err and err_cnt hold. No error detection. clr_err is still honoured.
- en=1, per-bit next state for bit i:
  - D: q[i] <= a[i].
  - T: q[i] <= q[i] ^ a[i].
  - SR:
    - a=0, b=0: hold.
    - a=1, b=0: set to 1.
    - a=0, b=1: clear to 0.
    - a=1, b=1: illegal. q[i] holds and the bit is flagged illegal this cycle.
  - JK:
    - 00: hold.
    - 10: set to 1.
    - 01: clear to 0.
    - 11: toggle. This is legal and never flags.
- Illegal detection applies only when en=1 and mode=10. Define ill[i] = a[i] & b[i] under that condition; any_ill = |ill.
- Error update without clr_err: err <= err | ill. If any_ill, err_cnt <= err_cnt+1, saturating at 2^CNT_W-1 with no wrap.
- Error update with clr_err=1 (and rst=0): err <= ill and err_cnt <= (any_ill ? 1 : 0). A clear never loses an error that occurs in the same cycle.
- Mode change: takes effect at the next edge. q is not disturbed by the change itself.
- Bits are independent: a mix of legal and illegal bits in SR mode updates the legal bits normally.
- Reset asserted mid-operation: takes effect at that edge regardless of the other inputs. After rst deasserts, normal operation resumes on the following edge.

Test Plan:
- Reset, WIDTH=8, RST_VAL=8'hA5: hold rst=1 for 2 edges -> q=A5, qbar=5A, err=00, err_cnt=0. Change a, b, mode with en=1 during reset -> q stays A5.
- D then T mode: mode=00, a=3C, en=1 -> q=3C after 1 edge. Then mode=01, a=FF -> q=C3. Then en=0, a=FF -> q stays C3.
- SR mode from q=00: a=0F, b=00 -> q=0F. Then a=00, b=03 -> q=0C. Then a=81, b=81 -> q=0C (bits 0 and 7 hold), err=81, err_cnt=1.
- JK mode from q=0C: a=FF, b=FF -> q=F3 with no err change. Then a=F0, b=0F -> q=F0.
- Counter saturation, CNT_W=4: hold SR a=b=01 for 20 edges -> err_cnt climbs to 15 and stays at 15, err[0]=1. Then clr_err=1 with a=b=02 -> err=02, err_cnt=1. Next, clr_err=1 with a=b=00 -> err=00, err_cnt=0.
- Gating: mode=10, en=0, a=b=FF -> no err and no err_cnt change. Assert rst in the same cycle as an illegal input with en=1 -> err=00, err_cnt=0, q=RST_VAL.
